multicycle_control: RTL and testbench

Main control FSM for the multicycle RV32I datapath. It sequences instruction fetch, decode, execute, memory access and write-back by driving the enables of the datapath's PC, IR and register-file registers, the memory strobes, the operand and result mux selects, and the ALU operation. It sits beside the datapath, takes decoded instruction fields, the ALU `zero` flag and a memory ready handshake, and stalls on slow memory.

---
 rtl/multicycle_control_pkg.sv | 81 ++++++++
 rtl/multicycle_control_alu_decoder.sv | 43 ++++
 rtl/multicycle_control.sv | 166 ++++++++++++++++
 tb/tb_multicycle_control.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle RV32I control unit: state encodings,
// datapath select codes, ALU operation codes and opcode constants.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_UPPER    = 4'd12,
    S_HALT     = 4'd13
  } state_e;

  // How the ALU decoder should pick the operation.
  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'd0,
    ALUOP_BRANCH = 2'd1,
    ALUOP_FUNCT  = 2'd2
  } alu_op_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_DATA   = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  // Branch outcome from funct3 and the ALU zero flag. SLT/SLTU leave 1 in
  // the result when "less than", so lt-type branches are taken on !zero.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
    case (f3)
      3'b000:         return zero;
      3'b001:         return !zero;
      3'b100, 3'b110: return !zero;
      3'b101, 3'b111: return zero;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decoder: turns the FSM's coarse alu_op plus the
// instruction fields into the 4-bit ALU operation code.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_control
);

  logic is_r;
  assign is_r = (opcode == OP_R);

  // Select the ALU operation for the current control step.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_BRANCH: begin
        case (funct3[2:1])
          2'b10:   alu_control = ALU_SLT;
          2'b11:   alu_control = ALU_SLTU;
          default: alu_control = ALU_SUB;
        endcase
      end
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I datapath. Only the state is
// registered; outputs decode from the state and, where the datapath needs
// it in the same cycle, from mem_ready, zero and funct3.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       adr_src,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       halted
);

  state_e  state_q, state_d;
  alu_op_e alu_op;

  // State register; reset abandons whatever instruction was in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state sequencing; mem_ready only matters in the memory states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default:           state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_UPPER:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // Datapath controls per state; reset masks every enable and strobe.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    alu_op     = ALUOP_ADD;
    halted     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_DATA;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_UPPER: begin
        alu_src_a = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_BRANCH;
        pc_write  = branch_taken(funct3, zero);
      end
      S_JAL: begin
        pc_write  = 1'b1;
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
      end
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      halted    = 1'b0;
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model that
// expands each instruction into its expected per-cycle control vectors.
module tb_multicycle_control;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                         A_XOR = 4'd4, A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                         A_SLT = 4'd8, A_SLTU = 4'd9;
  localparam logic [2:0] I_I = 3'd0, I_S = 3'd1, I_U = 3'd3;

  logic       clk, reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;

  logic       pc_write, ir_write, mem_read, mem_write, adr_src, reg_write, halted;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic       pc_write_n, ir_write_n, mem_read_n, mem_write_n, adr_src_n, reg_write_n, halted_n;
  logic [1:0] alu_src_a_n, alu_src_b_n, result_src_n;
  logic [2:0] imm_src_n;
  logic [3:0] alu_control_n;

  int total = 0;
  int bad   = 0;

  // Packed view: {pcw, irw, mrd, mwr, rw, halted, adr, a[2], b[2], res[2], imm[3], alu[4]}
  logic [19:0] obs, obs_n;
  assign obs   = {pc_write, ir_write, mem_read, mem_write, reg_write, halted, adr_src,
                  alu_src_a, alu_src_b, result_src, imm_src, alu_control};
  assign obs_n = {pc_write_n, ir_write_n, mem_read_n, mem_write_n, reg_write_n, halted_n, adr_src_n,
                  alu_src_a_n, alu_src_b_n, result_src_n, imm_src_n, alu_control_n};

  multicycle_control #(.ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .adr_src(adr_src), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .alu_control(alu_control), .halted(halted)
  );

  multicycle_control #(.ILLEGAL_HALT(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write_n), .ir_write(ir_write_n),
    .mem_read(mem_read_n), .mem_write(mem_write_n), .adr_src(adr_src_n), .reg_write(reg_write_n),
    .alu_src_a(alu_src_a_n), .alu_src_b(alu_src_b_n), .result_src(result_src_n),
    .imm_src(imm_src_n), .alu_control(alu_control_n), .halted(halted_n)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard queues: per-cycle drive and expectation for both instances
  logic [1:0]  drv_q[$];
  logic [19:0] exp_q[$], msk_q[$], exp2_q[$], msk2_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%05h expected=%05h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] ov(input logic pcw, irw, mrd, mwr, rw, hlt, adr,
                                     input logic [1:0] a, b, res, input logic [2:0] imm,
                                     input logic [3:0] alu);
    return {pcw, irw, mrd, mwr, rw, hlt, adr, a, b, res, imm, alu};
  endfunction

  // Enables/strobes/halted always checked; selects only where they matter.
  function automatic logic [19:0] mk(input logic adr, a, b, res, imm, alu);
    return {6'h3F, adr, {2{a}}, {2{b}}, {2{res}}, {3{imm}}, {4{alu}}};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // ALU operation an R/I instruction should request
  function automatic logic [3:0] exp_alu(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (is_r && f7) ? A_SUB : A_ADD;
      3'd1: return A_SLL;
      3'd2: return A_SLT;
      3'd3: return A_SLTU;
      3'd4: return A_XOR;
      3'd5: return f7 ? A_SRA : A_SRL;
      3'd6: return A_OR;
      default: return A_AND;
    endcase
  endfunction

  function automatic logic exp_taken(input logic [2:0] f3, input logic z);
    if (f3 == 3'd0) return z;
    if (f3 == 3'd1) return !z;
    if (f3 == 3'd4 || f3 == 3'd6) return !z;
    if (f3 == 3'd5 || f3 == 3'd7) return z;
    return 1'b0;
  endfunction

  task automatic push2(input string t, input logic mr, input logic z,
                       input logic [19:0] e, input logic [19:0] m,
                       input logic [19:0] e2, input logic [19:0] m2);
    tag_q.push_back(t);
    drv_q.push_back({mr, z});
    exp_q.push_back(e);   msk_q.push_back(m);
    exp2_q.push_back(e2); msk2_q.push_back(m2);
  endtask

  task automatic push(input string t, input logic mr, input logic z,
                      input logic [19:0] e, input logic [19:0] m);
    push2(t, mr, z, e, m, e, m);
  endtask

  task automatic push_fetch(input int fw, input logic z);
    for (int i = 0; i < fw; i++)
      push("fetch_wait", 1'b0, z, ov(0,0,1,0,0,0,0, 2'd0,2'd2,2'd2,3'd0,A_ADD), mk(1,1,1,1,0,1));
    push("fetch", 1'b1, z, ov(1,1,1,0,0,0,0, 2'd0,2'd2,2'd2,3'd0,A_ADD), mk(1,1,1,1,0,1));
    push("decode", rb(), z, ov(0,0,0,0,0,0,0, 2'd1,2'd1,2'd0,3'd0,A_ADD), mk(0,1,1,0,0,1));
  endtask

  task automatic push_aluwb(input logic z);
    push("aluwb", rb(), z, ov(0,0,0,0,1,0,0, 2'd0,2'd0,2'd0,3'd0,A_ADD), mk(0,0,0,1,0,0));
  endtask

  task automatic push_jal(input logic z);
    push("jal", rb(), z, ov(1,0,0,0,0,0,0, 2'd1,2'd2,2'd0,3'd0,A_ADD), mk(0,1,1,1,0,1));
    push_aluwb(z);
  endtask

  // Expand one legal instruction into its expected cycle sequence
  task automatic model_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw);
    push_fetch(fw, z);
    case (op)
      7'h03: begin
        push("ld_adr", rb(), z, ov(0,0,0,0,0,0,0, 2'd2,2'd1,2'd0,I_I,A_ADD), mk(0,1,1,0,1,1));
        for (int i = 0; i < mw; i++)
          push("ld_wait", 1'b0, z, ov(0,0,1,0,0,0,1, 2'd0,2'd0,2'd0,3'd0,A_ADD), mk(1,0,0,0,0,0));
        push("ld_read", 1'b1, z, ov(0,0,1,0,0,0,1, 2'd0,2'd0,2'd0,3'd0,A_ADD), mk(1,0,0,0,0,0));
        push("ld_wb", rb(), z, ov(0,0,0,0,1,0,0, 2'd0,2'd0,2'd1,3'd0,A_ADD), mk(0,0,0,1,0,0));
      end
      7'h23: begin
        push("st_adr", rb(), z, ov(0,0,0,0,0,0,0, 2'd2,2'd1,2'd0,I_S,A_ADD), mk(0,1,1,0,1,1));
        for (int i = 0; i < mw; i++)
          push("st_wait", 1'b0, z, ov(0,0,0,1,0,0,1, 2'd0,2'd0,2'd0,3'd0,A_ADD), mk(1,0,0,0,0,0));
        push("st_write", 1'b1, z, ov(0,0,0,1,0,0,1, 2'd0,2'd0,2'd0,3'd0,A_ADD), mk(1,0,0,0,0,0));
      end
      7'h33: begin
        push("exec_r", rb(), z, ov(0,0,0,0,0,0,0, 2'd2,2'd0,2'd0,3'd0,exp_alu(1'b1,f3,f7)), mk(0,1,1,0,0,1));
        push_aluwb(z);
      end
      7'h13: begin
        push("exec_i", rb(), z, ov(0,0,0,0,0,0,0, 2'd2,2'd1,2'd0,I_I,exp_alu(1'b0,f3,f7)), mk(0,1,1,0,1,1));
        push_aluwb(z);
      end
      7'h63: begin
        logic [3:0] alu;
        alu = (f3[2:1] == 2'b00) ? A_SUB : (f3[2:1] == 2'b10) ? A_SLT : A_SLTU;
        push("branch", rb(), z, ov(exp_taken(f3,z),0,0,0,0,0,0, 2'd2,2'd0,2'd0,3'd0,alu),
             mk(0,1,1,1,0,(f3[2:1] != 2'b01)));
      end
      7'h6F: push_jal(z);
      7'h67: begin
        push("jalr", rb(), z, ov(0,0,0,0,0,0,0, 2'd2,2'd1,2'd0,I_I,A_ADD), mk(0,1,1,0,1,1));
        push_jal(z);
      end
      7'h37: begin
        push("lui", rb(), z, ov(0,0,0,0,0,0,0, 2'd3,2'd1,2'd0,I_U,A_ADD), mk(0,1,1,0,1,1));
        push_aluwb(z);
      end
      default: begin
        push("auipc", rb(), z, ov(0,0,0,0,0,0,0, 2'd1,2'd1,2'd0,I_U,A_ADD), mk(0,1,1,0,1,1));
        push_aluwb(z);
      end
    endcase
  endtask

  // Driver: called just after a rising edge; one queue entry per cycle
  task automatic run_q();
    logic [1:0] d;
    logic [19:0] e, m, e2, m2;
    string t;
    while (exp_q.size() > 0) begin
      d = drv_q.pop_front();
      t = tag_q.pop_front();
      e = exp_q.pop_front();   m = msk_q.pop_front();
      e2 = exp2_q.pop_front(); m2 = msk2_q.pop_front();
      mem_ready = d[1];
      zero      = d[0];
      @(negedge clk);
      check({t, "/halt_cfg"}, obs & m, e & m);
      check({t, "/nop_cfg"}, obs_n & m2, e2 & m2);
      @(posedge clk); #1;
    end
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; funct3 = f3; funct7b5 = f7;
  endtask

  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic z, input int fw, input int mw);
    set_instr(op, f3, f7);
    model_instr(op, f3, f7, z, fw, mw);
    run_q();
  endtask

  task automatic check_reset_outputs(input string t);
    check({t, "/halt_cfg"}, obs & 20'hFC000, 20'h0);
    check({t, "/nop_cfg"}, obs_n & 20'hFC000, 20'h0);
  endtask

  logic [6:0] legal_ops [9];

  initial begin
    legal_ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    set_instr(7'h33, 3'd0, 1'b0);
    #12;
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases
    do_instr(7'h33, 3'd0, 1'b0, 1'b0, 0, 0);   // add
    do_instr(7'h33, 3'd0, 1'b1, 1'b1, 0, 0);   // sub
    do_instr(7'h03, 3'd2, 1'b0, 1'b0, 0, 2);   // lw, 2 wait cycles
    do_instr(7'h63, 3'd0, 1'b0, 1'b1, 0, 0);   // beq taken
    do_instr(7'h63, 3'd1, 1'b0, 1'b1, 0, 0);   // bne not taken
    do_instr(7'h63, 3'd7, 1'b0, 1'b0, 0, 0);   // bgeu not taken
    do_instr(7'h67, 3'd0, 1'b0, 1'b0, 0, 0);   // jalr
    do_instr(7'h6F, 3'd0, 1'b0, 1'b0, 1, 0);   // jal with fetch wait
    do_instr(7'h23, 3'd2, 1'b0, 1'b0, 0, 1);   // sw
    do_instr(7'h13, 3'd5, 1'b1, 1'b0, 0, 0);   // srai
    do_instr(7'h13, 3'd0, 1'b1, 1'b0, 0, 0);   // addi with bit30 set
    do_instr(7'h37, 3'd0, 1'b0, 1'b0, 0, 0);   // lui
    do_instr(7'h17, 3'd0, 1'b0, 1'b0, 0, 0);   // auipc

    // Illegal opcode: halt in one config, back to FETCH in the other
    set_instr(7'h00, 3'd0, 1'b0);
    push_fetch(0, 1'b0);
    for (int i = 0; i < 4; i++)
      push2("illegal", 1'b0, 1'b0,
            ov(0,0,0,0,0,1,0, 2'd0,2'd0,2'd0,3'd0,A_ADD), mk(0,0,0,0,0,0),
            ov(0,0,1,0,0,0,0, 2'd0,2'd2,2'd2,3'd0,A_ADD), mk(1,1,1,1,0,1));
    run_q();
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_outputs("halt_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    do_instr(7'h33, 3'd4, 1'b0, 1'b0, 0, 0);   // xor after halt recovery

    // Reset asserted while a store waits in MEMWRITE
    set_instr(7'h23, 3'd2, 1'b0);
    push_fetch(0, 1'b0);
    push("st_adr", 1'b0, 1'b0, ov(0,0,0,0,0,0,0, 2'd2,2'd1,2'd0,I_S,A_ADD), mk(0,1,1,0,1,1));
    push("st_wait", 1'b0, 1'b0, ov(0,0,0,1,0,0,1, 2'd0,2'd0,2'd0,3'd0,A_ADD), mk(1,0,0,0,0,0));
    run_q();
    mem_ready = 1'b0;
    #2;
    check("mw_before_reset", obs & 20'hFE000, 20'h12000);
    reset = 1'b1;
    #1;
    check_reset_outputs("mw_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    do_instr(7'h33, 3'd6, 1'b0, 1'b0, 0, 0);   // or: FETCH follows release

    // Random legal instructions with random memory waits
    for (int n = 0; n < 80; n++) begin
      logic [6:0] op;
      op = legal_ops[$urandom_range(0, 8)];
      do_instr(op, 3'($urandom_range(0, 7)), rb(), rb(),
               $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
